// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake/data bundle for sync_fifo.
//   master : drives flush, wr_en, wr_data, rd_en (producer/consumer side)
//   slave  : the FIFO; drives rd_data, full, empty, almost_full, count
//            (plus overflow/underflow when SYNC_FIFO_ERR_EN is defined)
interface sync_fifo_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
);
  logic                     flush;
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     rd_en;
  logic [WIDTH-1:0]         rd_data;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic [$clog2(DEPTH):0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic                     overflow;
  logic                     underflow;
`endif

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, count
`ifdef SYNC_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, count
`ifdef SYNC_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO, first-word-fall-through.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (clears pointers, count, storage)
//   bus   - sync_fifo_if.slave: flush, wr_en/wr_data push, rd_en pop,
//           rd_data (oldest entry), full/empty/almost_full, count
// Build option: define SYNC_FIFO_ERR_EN to add sticky overflow/underflow
//   flags (set by an ignored push/pop, cleared by reset or flush).
module sync_fifo #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  // Flags come only from the count register, so no wr_en/rd_en path reaches them.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = bus.wr_en & ~full;
  assign pop_ok  = bus.rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !bus.flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.rd_data     = mem[rd_ptr];
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count >= CW'(AFULL_THRESH));
  assign bus.count       = count;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow;
  logic underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wr_en && full)  overflow  <= 1'b1;
      if (bus.rd_en && empty) underflow <= 1'b1;
    end
  end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed + random stimulus for sync_fifo (WIDTH=64, DEPTH=8),
// compared each cycle against a queue-based reference model.
module tb_sync_fifo;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int AFT   = DEPTH - 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [WIDTH-1:0] q[$];
  logic             m_ov = 1'b0;
  logic             m_uf = 1'b0;
  int               n_pass  = 0;
  int               n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 64'(bus.count), 64'(q.size()));
    chk({tag, ".empty"}, 64'(bus.empty), 64'(q.size() == 0));
    chk({tag, ".full"},  64'(bus.full),  64'(q.size() == DEPTH));
    chk({tag, ".afull"}, 64'(bus.almost_full), 64'(q.size() >= AFT));
    if (q.size() > 0) chk({tag, ".rd_data"}, bus.rd_data, q[0]);
`ifdef SYNC_FIFO_ERR_EN
    chk({tag, ".overflow"},  64'(bus.overflow),  64'(m_ov));
    chk({tag, ".underflow"}, 64'(bus.underflow), 64'(m_uf));
`endif
  endtask

  // One clock cycle: apply inputs, advance the model by the FIFO rules, check.
  task automatic step(input string tag, input logic w, input logic [63:0] d,
                      input logic r, input logic f);
    bit push, pop;
    bus.wr_en = w; bus.wr_data = d; bus.rd_en = r; bus.flush = f;
    @(posedge clk);
    if (f) begin
      q.delete(); m_ov = 1'b0; m_uf = 1'b0;
    end else begin
      push = w && (q.size() < DEPTH);
      pop  = r && (q.size() > 0);
      if (w && !push) m_ov = 1'b1;
      if (r && !pop)  m_uf = 1'b1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
    end
    #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0;
    check_all(tag);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".count"}, 64'(bus.count), 64'd0);
    chk({tag, ".empty"}, 64'(bus.empty), 64'd1);
    chk({tag, ".full"},  64'(bus.full),  64'd0);
    chk({tag, ".afull"}, 64'(bus.almost_full), 64'd0);
    chk({tag, ".rd_data"}, bus.rd_data, 64'd0);
  endtask

  initial begin
    logic [63:0] v;
    bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;

    #2 rst_n = 1'b0;
    #1 reset_checks("in_reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1 reset_checks("post_reset");

    // Three pushes then three pops, order and count.
    step("p11", 1, 64'h11, 0, 0);
    step("p22", 1, 64'h22, 0, 0);
    step("p33", 1, 64'h33, 0, 0);
    chk("cnt3", 64'(bus.count), 64'd3);
    chk("head11", bus.rd_data, 64'h11);
    step("r1", 0, 0, 1, 0);
    chk("head22", bus.rd_data, 64'h22);
    step("r2", 0, 0, 1, 0);
    chk("head33", bus.rd_data, 64'h33);
    step("r3", 0, 0, 1, 0);
    chk("drained_empty", 64'(bus.empty), 64'd1);

    // Fill to full, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 64'h100 + 64'(i), 0, 0);
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_count", 64'(bus.count), 64'(DEPTH));
    step("push_dead", 1, 64'hDEAD, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_val", bus.rd_data, 64'h100 + 64'(i));
      step("drain", 0, 0, 1, 0);
    end

    // Occupancy held at 3 over 20 simultaneous push/pop cycles (pointers wrap).
    for (int i = 0; i < 3; i++) step("occ_fill", 1, 64'h200 + 64'(i), 0, 0);
    for (int i = 3; i < 23; i++) begin
      step("occ_pp", 1, 64'h200 + 64'(i), 1, 0);
      chk("occ_cnt", 64'(bus.count), 64'd3);
    end
    for (int i = 0; i < 3; i++) step("occ_drain", 0, 0, 1, 0);

    // Empty: push accepted, pop ignored.
    step("empty_both", 1, 64'h5A, 1, 0);
    chk("eb_data", bus.rd_data, 64'h5A);
    chk("eb_cnt", 64'(bus.count), 64'd1);
    for (int i = 0; i < DEPTH - 1; i++) step("refill", 1, 64'h300 + 64'(i), 0, 0);
    step("full_both", 1, 64'hBEEF, 1, 0);
    chk("fb_cnt", 64'(bus.count), 64'd7);

    // Flush overrides a push.
    step("flush0", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("to5", 1, 64'h400 + 64'(i), 0, 0);
    step("flush_wr", 1, 64'h999, 0, 1);
    chk("flush_cnt", 64'(bus.count), 64'd0);
    chk("flush_empty", 64'(bus.empty), 64'd1);

    // Sticky error flags (model tracks them; checked in check_all when enabled).
    step("uf_pop", 0, 0, 1, 0);
    step("uf_idle", 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("ov_fill", 1, 64'h500 + 64'(i), 0, 0);
    step("ov_push", 1, 64'h777, 0, 0);
    step("ov_idle", 0, 0, 0, 0);
    step("err_flush", 0, 0, 0, 1);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 4; i++) step("burst", 1, 64'h600 + 64'(i), 0, 0);
    #3 rst_n = 1'b0;
    #1 reset_checks("async_rst");
    q.delete(); m_ov = 1'b0; m_uf = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    #2;
    step("post_p", 1, 64'hA1, 0, 0);
    chk("post_head", bus.rd_data, 64'hA1);
    step("post_r", 0, 0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = {$urandom, $urandom};
      step("rand", 1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
